led_arbiter: RTL

Arbitrates the icestick LED bank between the four user switches. Each switch is synchronised and debounced. A press queues a display request, and a round-robin scheduler grants one request at a time. The granted switch's LED is lit for a fixed hold time, and LED5 reports activity. The block sits between the raw board pins and the LEDs, replacing direct switch-to-LED wiring in the top level.

---
 rtl/led_arbiter_pkg.sv | 36 +++
 rtl/led_arbiter_debounce.sv | 50 +++++
 rtl/led_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/led_arbiter_pkg.sv
// Shared types and the round-robin pick function for the LED arbiter.
// The pick searches ptr+1, ptr+2, ptr+3, then ptr itself (all mod 4).
package led_arbiter_pkg;

    localparam int NUM_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } pick_t;

    // Walk from the farthest candidate back to the nearest, so the nearest
    // pending index after ptr is the last (and winning) assignment.
    function automatic pick_t rr_pick(input logic [NUM_SW-1:0] pending,
                                      input logic [1:0]        ptr);
        pick_t      p;
        logic [1:0] cand;
        p.valid = 1'b0;
        p.idx   = ptr;
        for (int k = NUM_SW; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (pending[cand]) begin
                p.valid = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/led_arbiter_debounce.sv
// Switch conditioning: 2-flop synchroniser, consecutive-cycle debouncer and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // The flip happens on the cycle the disagreement count would reach
    // DEBOUNCE_CYCLES, so the counter never holds that value and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
                rise_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter granting the icestick LEDs to debounced switch presses.
// Define LED_ARBITER_AUTOREPEAT_EN to re-queue a still-held switch at grant end.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int HOLD_CYCLES     = 6000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SW1,
    input  logic SW2,
    input  logic SW3,
    input  logic SW4,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

`ifdef LED_ARBITER_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] level;
    logic [NUM_SW-1:0] rise;

    assign sw_raw = {SW4, SW3, SW2, SW1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            sw_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .sw_i   (sw_raw[gi]),
                .level_o(level[gi]),
                .rise_o (rise[gi])
            );
        end
    endgenerate

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NUM_SW-1:0] pending_q, pending_d;
    logic [NUM_SW-1:0] led_q;
    logic              busy_q;

    pick_t             pick;
    logic [NUM_SW-1:0] clr;
    logic [NUM_SW-1:0] rpt;
    logic [NUM_SW-1:0] grant_oh;

    assign grant_oh = NUM_SW'(1) << grant_q;

    always_comb begin
        pick    = rr_pick(pending_q, ptr_q);
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        clr     = '0;
        rpt     = '0;
        case (state_q)
            IDLE, GAP: begin
                if (pick.valid) begin
                    state_d        = SHOW;
                    grant_d        = pick.idx;
                    ptr_d          = pick.idx;
                    hold_d         = '0;
                    clr[pick.idx]  = 1'b1;
                end else if (state_q == GAP) begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = GAP;
                    hold_d  = '0;
                    // Any other pending request beats re-showing a held switch.
                    if (AUTOREPEAT && level[grant_q] && ((pending_q & ~grant_oh) == '0))
                        rpt = grant_oh;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new rise on the cycle of its own grant re-queues the request.
        pending_d = (pending_q & ~clr) | rise | rpt;
    end

    // Outputs are registered from next-state values so they line up with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'd0;
            ptr_q     <= 2'd3;
            hold_q    <= '0;
            pending_q <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            led_q     <= (state_d == SHOW) ? (NUM_SW'(1) << grant_d) : '0;
            busy_q    <= (pending_d != '0) || (state_d != IDLE);
        end
    end

    assign LED1 = led_q[0];
    assign LED2 = led_q[1];
    assign LED3 = led_q[2];
    assign LED4 = led_q[3];
    assign LED5 = busy_q;

endmodule
